// File: rtl/aibndaux_actred_cfg_rx.sv
// Captures one actred shift-enable word from the serial redundancy chain and holds it for the
// downstream shift-enable chain. Define AIBNDAUX_ACTRED_PARITY_EN to add an even-parity bit.
module aibndaux_actred_cfg_rx #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TMO_CNT = 255
) (
   input  logic              clk,
   input  logic              dig_rstb,
   input  logic              actred_chain_in,
   input  logic              capture_en,
   output logic [DATA_W-1:0] actred_shiften_vec,
   output logic              capture_busy,
   output logic              capture_done,
   output logic              capture_err,
   output logic [1:0]        err_code
);

   localparam int unsigned BitW = $clog2(DATA_W) + 1;
   localparam logic [7:0] TmoLast = 8'(TMO_CNT);
   localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

   localparam logic [1:0] ErrNone  = 2'b00;
   localparam logic [1:0] ErrTmo   = 2'b01;
   localparam logic [1:0] ErrFrame = 2'b11;
`ifdef AIBNDAUX_ACTRED_PARITY_EN
   localparam logic [1:0] ErrPar   = 2'b10;
`endif

   typedef enum logic [2:0] {
      StIdle, StWaitStart, StShift, StPar, StStop, StDone, StErr
   } state_e;

   state_e            state_q, state_d;
   logic              sync1_q, sync_q, prev_q;
   logic [7:0]        tmo_q, tmo_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] vec_q, vec_d;
   logic [1:0]        err_q, err_d;
   logic              busy_q, done_q, errf_q;
`ifdef AIBNDAUX_ACTRED_PARITY_EN
   logic              par_bad_q, par_bad_d;
`endif

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      vec_d   = vec_q;
      err_d   = err_q;
`ifdef AIBNDAUX_ACTRED_PARITY_EN
      par_bad_d = par_bad_q;
`endif
      case (state_q)
         StIdle: begin
            if (capture_en) begin
               state_d = StWaitStart;
               tmo_d   = '0;
            end
         end
         StWaitStart: begin
            if (!capture_en) begin
               state_d = StIdle;
            end else if (sync_q && !prev_q) begin
               state_d = StShift;
               bit_d   = '0;
            end else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_d == TmoLast) begin
                  state_d = StErr;
                  err_d   = ErrTmo;
               end
            end
         end
         StShift: begin
            if (!capture_en) begin
               state_d = StIdle;
            end else begin
               // LSB first: after DATA_W shifts the first bit sits in bit 0
               shreg_d = {sync_q, shreg_q[DATA_W-1:1]};
               bit_d   = bit_q + BitW'(1);
               if (bit_q == BitLast) begin
`ifdef AIBNDAUX_ACTRED_PARITY_EN
                  state_d = StPar;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef AIBNDAUX_ACTRED_PARITY_EN
         StPar: begin
            if (!capture_en) begin
               state_d = StIdle;
            end else begin
               par_bad_d = ^{shreg_q, sync_q};
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            // Not abortable; framing outranks parity
            if (sync_q) begin
               state_d = StErr;
               err_d   = ErrFrame;
            end
`ifdef AIBNDAUX_ACTRED_PARITY_EN
            else if (par_bad_q) begin
               state_d = StErr;
               err_d   = ErrPar;
            end
`endif
            else begin
               state_d = StDone;
               vec_d   = shreg_q;
            end
         end
         StDone, StErr: begin
            if (!capture_en) begin
               state_d = StIdle;
               err_d   = ErrNone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge dig_rstb) begin
      if (!dig_rstb) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         state_q <= StIdle;
         tmo_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         vec_q   <= '0;
         err_q   <= ErrNone;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         errf_q  <= 1'b0;
`ifdef AIBNDAUX_ACTRED_PARITY_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         sync1_q <= actred_chain_in;
         sync_q  <= sync1_q;
         prev_q  <= sync_q;
         state_q <= state_d;
         tmo_q   <= tmo_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         // Status flags follow the next state so they are valid on entry
         busy_q  <= state_d inside {StWaitStart, StShift, StPar, StStop};
         done_q  <= (state_d == StDone);
         errf_q  <= (state_d == StErr);
`ifdef AIBNDAUX_ACTRED_PARITY_EN
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign actred_shiften_vec = vec_q;
   assign capture_busy       = busy_q;
   assign capture_done       = done_q;
   assign capture_err        = errf_q;
   assign err_code           = err_q;

endmodule

// File: tb/tb_aibndaux_actred_cfg_rx.sv
// Scoreboard bench for aibndaux_actred_cfg_rx: expected results are queued with each capture and
// checked by a monitor whenever capture_done or capture_err rises.
module tb_aibndaux_actred_cfg_rx;

   localparam int unsigned DW  = 16;
   localparam int unsigned TMO = 12;

   logic          clk = 1'b0;
   logic          dig_rstb = 1'b0;
   logic          chain = 1'b0;
   logic          capture_en = 1'b0;
   logic [DW-1:0] vec;
   logic          busy, done, err;
   logic [1:0]    code;

   always #5 clk = ~clk;

   aibndaux_actred_cfg_rx #(
      .DATA_W (DW),
      .TMO_CNT(TMO)
   ) dut (
      .clk               (clk),
      .dig_rstb          (dig_rstb),
      .actred_chain_in   (chain),
      .capture_en        (capture_en),
      .actred_shiften_vec(vec),
      .capture_busy      (busy),
      .capture_done      (done),
      .capture_err       (err),
      .err_code          (code)
   );

   typedef struct packed {
      logic          done;
      logic          err;
      logic [1:0]    code;
      logic [DW-1:0] vec;
   } resp_t;

   resp_t         exp_q[$];
   resp_t         mon_e;
   int            n_tests = 0;
   int            n_fail = 0;
   logic [DW-1:0] model_vec = '0;
   logic          out_prev = 1'b0;
   logic          last_par = 1'b0;

   function automatic resp_t mk(input logic d, input logic e, input logic [1:0] c,
                                input logic [DW-1:0] v);
      mk = {d, e, c, v};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare each presented result against the head of the scoreboard
   always @(negedge clk) begin
      if ((done || err) && !out_prev) begin
         check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
         check("flags_exclusive", {busy, done, err}, done ? 3'b010 : 3'b001);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("result", {done, err, code, vec}, mon_e);
         end
      end
      out_prev = done | err;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic start_capture();
      capture_en = 1'b1;
      chain      = 1'b0;
      tick(1);
      check("busy_on_entry", busy, 1'b1);
      tick(2);
   endtask

   task automatic send_frame(input logic [DW-1:0] w, input logic par, input logic stp);
      last_par = par;
      chain = 1'b1;
      tick(1);
      for (int i = 0; i < int'(DW); i++) begin
         chain = w[i];
         tick(1);
      end
`ifdef AIBNDAUX_ACTRED_PARITY_EN
      chain = par;
      tick(1);
`endif
      chain = stp;
      tick(1);
      chain = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int k;
      k = 0;
      while (!(done || err) && k < 20) begin
         tick(1);
         k++;
      end
      check(name, done | err, 1'b1);
   endtask

   task automatic release_en(input string name);
      capture_en = 1'b0;
      tick(1);
      check(name, {busy, done, err, code}, 5'b0);
   endtask

   initial begin
      int k;
      // Reset
      tick(2);
      check("reset_state", {vec, busy, done, err, code}, '0);
      #2 dig_rstb = 1'b1;
      tick(1);

      // Good word
      model_vec = 16'hA5C3;
      exp_q.push_back(mk(1'b1, 1'b0, 2'b00, model_vec));
      start_capture();
      send_frame(16'hA5C3, 1'b0, 1'b0);
      wait_result("good_resp");
      release_en("good_idle");

      // Timeout: chain held low
      exp_q.push_back(mk(1'b0, 1'b1, 2'b01, model_vec));
      capture_en = 1'b1;
      tick(1);
      k = 0;
      while (!err && k < 3 * int'(TMO)) begin
         tick(1);
         k++;
      end
      check("tmo_latency", 64'(k), 64'(TMO));
      release_en("tmo_idle");

      // Parity error (only detectable when parity is framed)
`ifdef AIBNDAUX_ACTRED_PARITY_EN
      exp_q.push_back(mk(1'b0, 1'b1, 2'b10, model_vec));
`else
      model_vec = 16'h0001;
      exp_q.push_back(mk(1'b1, 1'b0, 2'b00, model_vec));
`endif
      start_capture();
      send_frame(16'h0001, 1'b0, 1'b0);
      wait_result("par_resp");
      release_en("par_idle");

      // Framing error, then framing plus bad parity
      exp_q.push_back(mk(1'b0, 1'b1, 2'b11, model_vec));
      start_capture();
      send_frame(16'hA5C3, 1'b0, 1'b1);
      wait_result("frame_resp");
      release_en("frame_idle");

      exp_q.push_back(mk(1'b0, 1'b1, 2'b11, model_vec));
      start_capture();
      send_frame(16'h0001, 1'b0, 1'b1);
      wait_result("frame_par_resp");
      release_en("frame_par_idle");

      // Abort after 5 data bits
      start_capture();
      chain = 1'b1;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         chain = i[0];
         tick(1);
      end
      check("busy_before_abort", busy, 1'b1);
      capture_en = 1'b0;
      chain      = 1'b0;
      tick(1);
      check("abort_idle", {vec, busy, done, err, code}, {model_vec, 5'b0});

      // Reset pulse in SHIFT
      start_capture();
      chain = 1'b1;
      tick(1);
      for (int i = 0; i < 4; i++) begin
         chain = 1'b1;
         tick(1);
      end
      check("busy_before_reset", busy, 1'b1);
      #2 dig_rstb = 1'b0;
      #1;
      check("reset_mid_shift", {vec, busy, done, err, code}, '0);
      model_vec  = '0;
      capture_en = 1'b0;
      chain      = 1'b0;
      tick(1);
      dig_rstb = 1'b1;
      tick(1);
      check("post_reset_idle", {vec, busy, done, err, code}, '0);

      // Back-to-back captures
      model_vec = 16'hFFFF;
      exp_q.push_back(mk(1'b1, 1'b0, 2'b00, model_vec));
      start_capture();
      send_frame(16'hFFFF, 1'b0, 1'b0);
      wait_result("b2b_ones_resp");
      release_en("b2b_ones_idle");

      model_vec = 16'h0000;
      exp_q.push_back(mk(1'b1, 1'b0, 2'b00, model_vec));
      start_capture();
      send_frame(16'h0000, 1'b0, 1'b0);
      wait_result("b2b_zeros_resp");
      release_en("b2b_zeros_idle");

      tick(5);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
